// File: rtl/level_generator.sv
// Converts single-cycle request/response pulses into transaction level signals.
// Optional watchdog counter and timeout flag are compiled in with LVL_GEN_TIMEOUT_EN.
module level_generator #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_read_pul,
  input  logic       s_write_pul,
  input  logic       t_valid_pul,
  input  logic       trans_error_pul,
  output logic       s_read,
  output logic       s_write,
  output logic       t_valid,
  output logic       trans_error,
  output logic       timeout,
  output logic       coll_pul,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_e;

  // Elaboration-time guard: the counter must be able to reach TIMEOUT_CYCLES-1.
  if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535) ||
      ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES))) begin : g_bad_cfg
    $error("level_generator: illegal TIMEOUT_CYCLES/CNT_W combination");
  end

  state_e state_q, state_d;
  logic   s_read_q, s_read_d;
  logic   s_write_q, s_write_d;
  logic   t_valid_q, t_valid_d;
  logic   trans_error_q, trans_error_d;
  logic   coll_q, coll_d;

  // Control strobes shared with the optional watchdog.
  logic   open_start;   // entering RD or WR this edge
  logic   expire;       // watchdog reached its last cycle
  logic   to_set;       // close the transaction on expiry

`ifdef LVL_GEN_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  assign expire = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    t_valid_d     = t_valid_q;
    trans_error_d = trans_error_q;
    coll_d        = 1'b0;
    open_start    = 1'b0;
    to_set        = 1'b0;

    case (state_q)
      IDLE: begin
        // Read wins a simultaneous request; the losing write is reported.
        if (s_read_pul) begin
          state_d    = RD;
          open_start = 1'b1;
          coll_d     = s_write_pul;
        end else if (s_write_pul) begin
          state_d    = WR;
          open_start = 1'b1;
        end
        if (open_start) begin
          t_valid_d     = 1'b0;
          trans_error_d = 1'b0;
        end
      end
      RD, WR: begin
        // Any request while open is dropped, even alongside a termination.
        coll_d = s_read_pul | s_write_pul;
        if (trans_error_pul) begin
          state_d       = IDLE;
          trans_error_d = 1'b1;
        end else if (t_valid_pul) begin
          state_d   = IDLE;
          t_valid_d = 1'b1;
        end else if (expire) begin
          state_d = IDLE;
          to_set  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_read_d  = (state_d == RD);
    s_write_d = (state_d == WR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      s_read_q      <= 1'b0;
      s_write_q     <= 1'b0;
      t_valid_q     <= 1'b0;
      trans_error_q <= 1'b0;
      coll_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      s_read_q      <= s_read_d;
      s_write_q     <= s_write_d;
      t_valid_q     <= t_valid_d;
      trans_error_q <= trans_error_d;
      coll_q        <= coll_d;
    end
  end

`ifdef LVL_GEN_TIMEOUT_EN
  // Counter runs only while open and restarts from zero on every new open.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (open_start) begin
      timeout_d = 1'b0;
    end else if (to_set) begin
      timeout_d = 1'b1;
    end
    if ((state_q != IDLE) && (state_d != IDLE)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign s_read      = s_read_q;
  assign s_write     = s_write_q;
  assign t_valid     = t_valid_q;
  assign trans_error = trans_error_q;
  assign coll_pul    = coll_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator: vector table plus multi-cycle sequences.
// The timeout sequence is selected by LVL_GEN_TIMEOUT_EN, matching the DUT build.
`timescale 1ns/1ps
module tb_level_generator;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_read_pul = 1'b0, s_write_pul = 1'b0;
  logic       t_valid_pul = 1'b0, trans_error_pul = 1'b0;
  logic       s_read, s_write, t_valid, trans_error, timeout, coll_pul;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  level_generator #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .s_read_pul(s_read_pul), .s_write_pul(s_write_pul),
    .t_valid_pul(t_valid_pul), .trans_error_pul(trans_error_pul),
    .s_read(s_read), .s_write(s_write), .t_valid(t_valid),
    .trans_error(trans_error), .timeout(timeout), .coll_pul(coll_pul),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r, w, v, e;
    logic [5:0] exp;  // {s_read, s_write, t_valid, trans_error, timeout, coll_pul}
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] outs();
    return {s_read, s_write, t_valid, trans_error, timeout, coll_pul};
  endfunction

  // Called 1ns after a rising edge; holds pulses for exactly one sampling edge.
  task automatic drive(input logic r, input logic w, input logic v, input logic e);
    s_read_pul = r; s_write_pul = w; t_valid_pul = v; trans_error_pul = e;
    @(posedge clk); #1;
    s_read_pul = 0; s_write_pul = 0; t_valid_pul = 0; trans_error_pul = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic vec_t mk(input logic r, w, v, e, input logic [5:0] exp);
    vec_t t;
    t.r = r; t.w = w; t.v = v; t.e = e; t.exp = exp;
    return t;
  endfunction

  initial begin
    int n;
    int bad;

    // Reset state, checked before any clock edge.
    #2;
    check("reset_outs", 32'(outs()), 32'h0);
    check("reset_state", 32'(dbg_state), 32'h0);
    do_reset();

    // Expected: {rd, wr, tv, te, to, coll}
    vecs.push_back(mk(0, 0, 0, 0, 6'b000000)); // idle
    vecs.push_back(mk(0, 0, 1, 0, 6'b000000)); // t_valid ignored in idle
    vecs.push_back(mk(0, 0, 0, 1, 6'b000000)); // error ignored in idle
    vecs.push_back(mk(1, 0, 0, 0, 6'b100000)); // open read
    vecs.push_back(mk(0, 0, 0, 0, 6'b100000));
    vecs.push_back(mk(0, 1, 0, 0, 6'b100001)); // write dropped while open
    vecs.push_back(mk(0, 0, 1, 0, 6'b001000)); // complete
    vecs.push_back(mk(0, 0, 0, 0, 6'b001000)); // sticky
    vecs.push_back(mk(1, 1, 0, 0, 6'b100001)); // read wins, collision
    vecs.push_back(mk(0, 0, 1, 1, 6'b000100)); // error beats valid
    vecs.push_back(mk(0, 1, 0, 0, 6'b010000)); // open write clears flag
    vecs.push_back(mk(1, 0, 1, 0, 6'b001001)); // request with termination dropped
    vecs.push_back(mk(0, 1, 0, 0, 6'b010000)); // accepted right after return
    vecs.push_back(mk(0, 0, 1, 1, 6'b000100)); // write: error beats valid
    vecs.push_back(mk(0, 0, 1, 0, 6'b000100)); // idle valid leaves error
    foreach (vecs[i]) begin
      drive(vecs[i].r, vecs[i].w, vecs[i].v, vecs[i].e);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
    end

    // Read at cycle 0, valid at cycle 5.
    do_reset();
    drive(1, 0, 0, 0);
    check("seq_rd_c1", 32'({s_read, coll_pul}), 32'b10);
    for (int k = 2; k <= 5; k++) begin
      drive(0, 0, 0, 0);
      check($sformatf("seq_rd_c%0d", k), 32'({s_read, coll_pul}), 32'b10);
    end
    drive(0, 0, 1, 0);
    check("seq_rd_c6", 32'(outs()), 32'b001000);

`ifdef LVL_GEN_TIMEOUT_EN
    do_reset();
    drive(1, 0, 0, 0);
    n = 0;
    while (s_read && n < 20) begin
      n++;
      drive(0, 0, 0, 0);
    end
    check("to_level_len", 32'(n), 32'(TO));
    check("to_flag", 32'(outs()), 32'b000010);
    drive(1, 0, 0, 0);
    check("to_reopen", 32'(outs()), 32'b100000);
    drive(0, 0, 1, 0);
    // Valid on the expiry cycle wins over the timeout.
    drive(1, 0, 0, 0);
    for (int k = 0; k < TO - 1; k++) drive(0, 0, 0, 0);
    check("to_last_cycle_open", 32'(s_read), 32'd1);
    drive(0, 0, 1, 0);
    check("to_valid_prec", 32'(outs()), 32'b001000);
`else
    do_reset();
    drive(1, 0, 0, 0);
    bad = 0;
    for (int k = 0; k < 2000; k++) begin
      if (!(s_read === 1'b1 && timeout === 1'b0)) bad++;
      drive(0, 0, 0, 0);
    end
    check("hold_2000_bad_cycles", 32'(bad), 32'd0);
    check("hold_2000_end", 32'(outs()), 32'b100000);
    drive(0, 0, 1, 0);
    check("hold_close", 32'(outs()), 32'b001000);
`endif

    // Asynchronous reset in cycle 3 of an open write.
    do_reset();
    drive(0, 1, 0, 0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check("rst_wr_open", 32'(s_write), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async_outs", 32'(outs()), 32'h0);
    check("rst_async_state", 32'(dbg_state), 32'h0);
    #4 reset_n = 1'b1;
    s_read_pul = 1'b1;
    @(posedge clk); #1;
    s_read_pul = 1'b0;
    check("rst_first_edge_read", 32'(outs()), 32'b100000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout_guard: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
